silife_frame_buffer: RTL

Double-buffered cell-grid store between the life simulation engine and the `silife_max7219` display driver. The engine writes a full generation row by row into the back bank, then commits it. The buffer swaps banks only while the display driver is idle, and pulses a frame strobe that restarts the driver's scan. The driver reads the front bank combinationally by row index, so it always sees a stable, complete generation.

---
 rtl/silife_frame_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/silife_frame_buffer.sv
// Double-buffered cell-grid store between the life engine and the MAX7219 driver.
// The engine fills the back bank, then commits it. The bank pointer flips only while the
// display is idle, and a one-cycle frame strobe restarts the driver's scan.
module silife_frame_buffer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned HEIGHT = 32,
    localparam int unsigned RowBits = $clog2(HEIGHT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr_en,
    input  logic [RowBits-1:0] i_wr_row,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_commit,
    input  logic               i_clear,
    output logic               o_wr_ready,
    output logic               o_pending,
    input  logic [RowBits-1:0] i_rd_row,
    output logic [WIDTH-1:0]   o_rd_data,
    input  logic               i_display_busy,
    output logic               o_frame
);

    localparam logic [RowBits-1:0] LastRow = RowBits'(HEIGHT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StPending
    } state_e;

    state_e             state_q, state_d;
    logic               front_sel_q, front_sel_d;
    logic               frame_q, frame_d;
    logic [RowBits-1:0] clr_cnt_q, clr_cnt_d;

    // Single back-bank write port shared by engine writes and the zero-fill sweep.
    logic               we;
    logic [RowBits-1:0] we_row;
    logic [WIDTH-1:0]   we_data;

    logic [WIDTH-1:0] bank_q [2][HEIGHT];

    logic wr_in_range;
    logic rd_in_range;

    // Row indices can only exceed the bank when HEIGHT is not a power of two.
    if (HEIGHT == (1 << RowBits)) begin : g_pow2
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_npow2
        localparam logic [RowBits:0] HeightL = (RowBits + 1)'(HEIGHT);
        assign wr_in_range = ({1'b0, i_wr_row} < HeightL);
        assign rd_in_range = ({1'b0, i_rd_row} < HeightL);
    end

    // Next-state decode; frame strobe is only raised on the swap itself.
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        frame_d     = 1'b0;
        clr_cnt_d   = clr_cnt_q;
        we          = 1'b0;
        we_row      = i_wr_row;
        we_data     = i_wr_data;
        case (state_q)
            StIdle: begin
                // A write in the same cycle as commit joins the committed frame;
                // with clear it lands first and is then zeroed by the sweep.
                if (i_wr_en && wr_in_range) begin
                    we = 1'b1;
                end
                if (i_clear) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end else if (i_commit) begin
                    state_d = StPending;
                end
            end
            StClear: begin
                we      = 1'b1;
                we_row  = clr_cnt_q;
                we_data = '0;
                if (clr_cnt_q == LastRow) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + RowBits'(1);
                end
            end
            StPending: begin
                if (!i_display_busy) begin
                    state_d     = StIdle;
                    front_sel_d = ~front_sel_q;
                    frame_d     = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            front_sel_q <= 1'b0;
            frame_q     <= 1'b0;
            clr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            frame_q     <= frame_d;
            clr_cnt_q   <= clr_cnt_d;
        end
    end

    // Bank storage; only the back bank (opposite the front pointer) is ever written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(HEIGHT); r++) begin
                    bank_q[b][r] <= '0;
                end
            end
        end else if (we) begin
            bank_q[~front_sel_q][we_row] <= we_data;
        end
    end

    assign o_rd_data  = rd_in_range ? bank_q[front_sel_q][i_rd_row] : '0;
    assign o_frame    = frame_q;
    assign o_pending  = (state_q == StPending);
    assign o_wr_ready = (state_q == StIdle);

endmodule
